seven_segment_decoder: RTL and testbench

//  Receive side of the multiplexed seven-segment interface: samples a scanned abcdefgh/digit bus
//  and rebuilds the hex number and dots shown on the display. Sits in lab benches and on GPIO

---
 rtl/seven_segment_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_seven_segment_decoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder
//   Receive side of a multiplexed seven-segment display bus. Samples the
//   scanned abcdefgh/digit lines, waits until a pattern has been stable for
//   stable_cycles, then decodes the glyph back into a hex nibble and a dot
//   for the strobed position. Rebuilds the whole displayed number over a scan.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   abcdefgh   in   segment bus, bit7=a .. bit1=g, bit0=h (dot)
//   digit      in   position strobe, one-hot when valid
//   number     out  decoded hex nibbles, nibble i belongs to digit[i]
//   dots       out  captured dot per position
//   valid      out  last capture at that position was a legal glyph
//   frame_done out  one-cycle pulse when every position has been captured
//   error      out  one-cycle pulse on illegal glyph or newly seen multi-hot digit
module seven_segment_decoder #(
  parameter int w_digit            = 8,
  parameter int stable_cycles      = 4,
  parameter bit segment_active_low = 1'b0,
  parameter bit digit_active_low   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             abcdefgh,
  input  logic [w_digit-1:0]     digit,
  output logic [4*w_digit-1:0]   number,
  output logic [w_digit-1:0]     dots,
  output logic [w_digit-1:0]     valid,
  output logic                   frame_done,
  output logic                   error
);

  localparam int iw = (w_digit > 1) ? $clog2(w_digit) : 1;
  localparam int cw = $clog2(stable_cycles + 1);
  localparam logic [cw-1:0] stable_val = cw'(stable_cycles);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HELD    = 2'd3;

  logic [7:0]           s_seg, p_seg;
  logic [w_digit-1:0]   s_dig, p_dig;
  logic [1:0]           state, state_n;
  logic [cw-1:0]        count, count_n, count_inc;
  logic [w_digit-1:0]   seen, seen_n;
  logic [4*w_digit-1:0] number_n;
  logic [w_digit-1:0]   dots_n, valid_n;
  logic                 frame_n, error_n;
  logic                 s_one_hot, s_multi_hot, same;
  logic [iw-1:0]        idx;
  logic                 glyph_legal;
  logic [3:0]           glyph_value;
  logic                 settle_start, do_capture;

  // Input register with polarity normalization, followed by the previous
  // sample used to detect whether the bus has held still.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg <= '0;
      s_dig <= '0;
      p_seg <= '0;
      p_dig <= '0;
    end else begin
      s_seg <= abcdefgh ^ {8{segment_active_low}};
      s_dig <= digit ^ {w_digit{digit_active_low}};
      p_seg <= s_seg;
      p_dig <= s_dig;
    end
  end

  // x & (x-1) clears the lowest set bit, so a nonzero result means two or
  // more strobes are active at once.
  always_comb begin
    s_multi_hot = (s_dig & (s_dig - 1'b1)) != '0;
    s_one_hot   = (s_dig != '0) && !s_multi_hot;
    same        = (s_dig == p_dig) && (s_seg == p_seg);
    count_inc   = count + 1'b1;
    idx         = '0;
    for (int i = 0; i < w_digit; i++) begin
      if (s_dig[i]) idx = iw'(i);
    end
  end

  // Glyph table lookup; the dot bit is forced to zero so it never affects
  // legality.
  always_comb begin
    glyph_legal = 1'b1;
    glyph_value = 4'h0;
    case ({s_seg[7:1], 1'b0})
      8'hFC: glyph_value = 4'h0;
      8'h60: glyph_value = 4'h1;
      8'hDA: glyph_value = 4'h2;
      8'hF2: glyph_value = 4'h3;
      8'h66: glyph_value = 4'h4;
      8'hB6: glyph_value = 4'h5;
      8'hBE: glyph_value = 4'h6;
      8'hE0: glyph_value = 4'h7;
      8'hFE: glyph_value = 4'h8;
      8'hF6: glyph_value = 4'h9;
      8'hEE: glyph_value = 4'hA;
      8'h3E: glyph_value = 4'hB;
      8'h9C: glyph_value = 4'hC;
      8'h7A: glyph_value = 4'hD;
      8'h9E: glyph_value = 4'hE;
      8'h8E: glyph_value = 4'hF;
      default: glyph_legal = 1'b0;
    endcase
  end

  // Settle/capture state machine. The capture itself is performed on the
  // edge where the counter reaches stable_cycles so the outputs update
  // exactly stable_cycles edges after the pattern was first registered;
  // the CAPTURE state only marks that single cycle and then behaves like HELD.
  always_comb begin
    state_n      = state;
    count_n      = count;
    seen_n       = seen;
    number_n     = number;
    dots_n       = dots;
    valid_n      = valid;
    frame_n      = 1'b0;
    error_n      = 1'b0;
    settle_start = 1'b0;
    do_capture   = 1'b0;

    case (state)
      IDLE: begin
        if (s_one_hot) settle_start = 1'b1;
      end
      SETTLE: begin
        if (!s_one_hot)                state_n      = IDLE;
        else if (!same)                settle_start = 1'b1;
        else if (count_inc >= stable_val) do_capture = 1'b1;
        else                           count_n      = count_inc;
      end
      default: begin
        if (same)           state_n      = HELD;
        else if (s_one_hot) settle_start = 1'b1;
        else                state_n      = IDLE;
      end
    endcase

    // A fresh one-hot pattern counts as its first stable cycle already.
    if (settle_start) begin
      if (stable_cycles == 1) begin
        do_capture = 1'b1;
      end else begin
        state_n = SETTLE;
        count_n = cw'(1);
      end
    end

    // The completing capture both pulses frame_done and is the only
    // capture of that edge, so clearing seen loses nothing.
    if (do_capture) begin
      state_n     = CAPTURE;
      count_n     = '0;
      dots_n[idx] = s_seg[0];
      if (glyph_legal) begin
        number_n[{idx, 2'b00} +: 4] = glyph_value;
        valid_n[idx]                = 1'b1;
      end else begin
        valid_n[idx] = 1'b0;
        error_n      = 1'b1;
      end
      seen_n = seen | s_dig;
      if (&seen_n) begin
        frame_n = 1'b1;
        seen_n  = '0;
      end
    end

    // Multi-hot is only flagged on the cycle it first appears.
    if (s_multi_hot && (s_dig != p_dig)) error_n = 1'b1;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      seen       <= '0;
      number     <= '0;
      dots       <= '0;
      valid      <= '0;
      frame_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      seen       <= seen_n;
      number     <= number_n;
      dots       <= dots_n;
      valid      <= valid_n;
      frame_done <= frame_n;
      error      <= error_n;
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb_seven_segment_decoder
//   Drives two decoders side by side: one with true-polarity wires and one
//   with both buses inverted, fed the complement of the same stimulus. A
//   run-length reference model predicts the outputs after every clock edge;
//   a monitor pops those predictions and compares both decoders.
module tb_seven_segment_decoder;

  localparam int STABLE = 4;

  typedef struct {
    logic [31:0] number;
    logic [7:0]  dots;
    logic [7:0]  valid;
    logic        frame;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_a = '0, seg_b = '1;
  logic [7:0]  dig_a = '0, dig_b = '1;
  logic [31:0] number_a, number_b;
  logic [7:0]  dots_a, dots_b, valid_a, valid_b;
  logic        frame_a, frame_b, error_a, error_b;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];

  logic [7:0] glyph_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  // Reference model state: what the display has shown and for how long.
  logic [3:0] m_num [8];
  logic [7:0] m_dot, m_val, m_seen;
  logic [7:0] m_s_dig, m_s_seg, m_p_dig;
  int         m_run;

  seven_segment_decoder #(
    .w_digit(8), .stable_cycles(STABLE), .segment_active_low(1'b0), .digit_active_low(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .abcdefgh(seg_a), .digit(dig_a),
    .number(number_a), .dots(dots_a), .valid(valid_a),
    .frame_done(frame_a), .error(error_a)
  );

  seven_segment_decoder #(
    .w_digit(8), .stable_cycles(STABLE), .segment_active_low(1'b1), .digit_active_low(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .abcdefgh(seg_b), .digit(dig_b),
    .number(number_b), .dots(dots_b), .valid(valid_b),
    .frame_done(frame_b), .error(error_b)
  );

  always #5 clk = ~clk;

  // Keeps a hung run from going on forever.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Predicts the outputs after the coming edge, then advances the model's
  // view of the registered sample to the value being driven now.
  task automatic modelStep(input bit r, input logic [7:0] dig, input logic [7:0] seg);
    exp_t e;
    int   pos;
    int   found;
    e.frame = 1'b0;
    e.err   = 1'b0;
    if (r) begin
      for (int i = 0; i < 8; i++) m_num[i] = 4'h0;
      m_dot = '0; m_val = '0; m_seen = '0;
      m_s_dig = '0; m_s_seg = '0; m_p_dig = '0;
      m_run = 0;
    end else begin
      if ($countones(m_s_dig) == 1 && m_run == STABLE) begin
        pos = 0;
        for (int i = 0; i < 8; i++) if (m_s_dig[i]) pos = i;
        m_dot[pos] = m_s_seg[0];
        found = -1;
        for (int g = 0; g < 16; g++) if ({m_s_seg[7:1], 1'b0} == glyph_tab[g]) found = g;
        if (found >= 0) begin
          m_num[pos] = 4'(found);
          m_val[pos] = 1'b1;
        end else begin
          m_val[pos] = 1'b0;
          e.err      = 1'b1;
        end
        m_seen[pos] = 1'b1;
        if (m_seen == 8'hFF) begin
          e.frame = 1'b1;
          m_seen  = '0;
        end
      end
      if ($countones(m_s_dig) > 1 && m_s_dig != m_p_dig) e.err = 1'b1;
      m_p_dig = m_s_dig;
      if (dig == m_s_dig && seg == m_s_seg) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run = 1;
      end
      m_s_dig = dig;
      m_s_seg = seg;
    end
    for (int i = 0; i < 8; i++) e.number[4*i +: 4] = m_num[i];
    e.dots  = m_dot;
    e.valid = m_val;
    sb.push_back(e);
  endtask

  // Drives one clock's worth of stimulus (true polarity to dut_a, inverted
  // to dut_b) and records the expected response.
  task automatic applyStimulus(input bit r, input logic [7:0] dig, input logic [7:0] seg);
    @(negedge clk);
    rst   = r;
    dig_a = dig;
    seg_a = seg;
    dig_b = ~dig;
    seg_b = ~seg;
    modelStep(r, dig, seg);
  endtask

  task automatic holdPattern(input logic [7:0] dig, input logic [7:0] seg, input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, dig, seg);
  endtask

  // Directed check of both decoders against fixed values under a mask.
  task automatic checkDirected(input string tag,
                               input logic [31:0] num_mask, input logic [31:0] num_exp,
                               input logic [7:0] val_mask, input logic [7:0] val_exp,
                               input logic [7:0] dot_mask, input logic [7:0] dot_exp);
    @(posedge clk);
    #1;
    checkOutput({tag, ".A.number"}, number_a & num_mask, num_exp);
    checkOutput({tag, ".A.valid"}, 32'(valid_a & val_mask), 32'(val_exp));
    checkOutput({tag, ".A.dots"}, 32'(dots_a & dot_mask), 32'(dot_exp));
    checkOutput({tag, ".B.number"}, number_b & num_mask, num_exp);
    checkOutput({tag, ".B.valid"}, 32'(valid_b & val_mask), 32'(val_exp));
    checkOutput({tag, ".B.dots"}, 32'(dots_b & dot_mask), 32'(dot_exp));
  endtask

  // Monitor: the decoder presents a registered result every cycle; compare
  // it with the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("A.number", number_a, e.number);
      checkOutput("A.dots", 32'(dots_a), 32'(e.dots));
      checkOutput("A.valid", 32'(valid_a), 32'(e.valid));
      checkOutput("A.frame_done", 32'(frame_a), 32'(e.frame));
      checkOutput("A.error", 32'(error_a), 32'(e.err));
      checkOutput("B.number", number_b, e.number);
      checkOutput("B.dots", 32'(dots_b), 32'(e.dots));
      checkOutput("B.valid", 32'(valid_b), 32'(e.valid));
      checkOutput("B.frame_done", 32'(frame_b), 32'(e.frame));
      checkOutput("B.error", 32'(error_b), 32'(e.err));
    end
  end

  initial begin
    logic [7:0] dig, seg;
    int         sel, b1, b2, len;

    // Reset with noise on the inputs, then an idle bus.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'($urandom), 8'($urandom));
    holdPattern(8'h00, 8'h00, 3);
    checkDirected("reset", 32'hFFFF_FFFF, 32'h0, 8'hFF, 8'h00, 8'hFF, 8'h00);

    // A single '3' on position 0.
    holdPattern(8'h01, 8'hF2, STABLE);
    holdPattern(8'h00, 8'h00, 2);
    checkDirected("single3", 32'h0000_000F, 32'h3, 8'h01, 8'h01, 8'h01, 8'h00);

    // Illegal glyph over the '3'.
    holdPattern(8'h01, 8'h02, 6);
    checkDirected("illegal", 32'h0000_000F, 32'h3, 8'h01, 8'h00, 8'h00, 8'h00);

    // Full scan 0..7 showing 1..8 with the dot on position 2.
    for (int p = 0; p < 8; p++) begin
      seg = glyph_tab[p + 1];
      if (p == 2) seg[0] = 1'b1;
      holdPattern(8'(1) << p, seg, 6);
    end
    checkDirected("scan", 32'hFFFF_FFFF, 32'h8765_4321, 8'hFF, 8'hFF, 8'hFF, 8'h04);

    // Short ghost of '4' followed by a held 'C' on position 1.
    holdPattern(8'h02, 8'h66, 3);
    holdPattern(8'h02, 8'h9C, 6);
    checkDirected("ghost", 32'hFFFF_FFFF, 32'h8765_43C1, 8'hFF, 8'hFF, 8'hFF, 8'h04);

    // Multi-hot digit held: one error pulse, nothing captured.
    holdPattern(8'h03, 8'hF2, 10);
    checkDirected("multihot", 32'hFFFF_FFFF, 32'h8765_43C1, 8'hFF, 8'hFF, 8'hFF, 8'h04);

    // Reset in the middle of a settle; the partial pattern must not land.
    holdPattern(8'h04, 8'hEE, 2);
    applyStimulus(1'b1, 8'h04, 8'hEE);
    holdPattern(8'h00, 8'h00, 6);
    checkDirected("midreset", 32'hFFFF_FFFF, 32'h0, 8'hFF, 8'h00, 8'hFF, 8'h00);

    // Random scanning with glitches, gaps, multi-hot strobes and resets.
    for (int it = 0; it < 300; it++) begin
      sel = int'($urandom_range(0, 99));
      len = int'($urandom_range(1, 7));
      if (sel < 3) begin
        for (int k = 0; k < int'($urandom_range(1, 2)); k++)
          applyStimulus(1'b1, 8'($urandom), 8'($urandom));
      end else if (sel < 8) begin
        holdPattern(8'h00, 8'($urandom), len);
      end else if (sel < 13) begin
        b1  = int'($urandom_range(0, 7));
        b2  = (b1 + 1 + int'($urandom_range(0, 6))) % 8;
        dig = (8'(1) << b1) | (8'(1) << b2);
        holdPattern(dig, 8'($urandom), len);
      end else begin
        dig = 8'(1) << $urandom_range(0, 7);
        if ($urandom_range(0, 99) < 85) begin
          seg    = glyph_tab[$urandom_range(0, 15)];
          seg[0] = 1'($urandom);
        end else begin
          seg = 8'($urandom);
        end
        holdPattern(dig, seg, len);
      end
    end
    holdPattern(8'h00, 8'h00, 2);

    @(negedge clk);
    checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
